// File: rtl/test_bist_pkg.sv
// Shared definitions for the exhaustive-pattern BIST controller.
// Holds the width defaults, MISR taps, state encoding and the MISR step function.
package test_bist_pkg;

   localparam int PAT_W_DEF = 5;
   localparam int RSP_W_DEF = 11;
   localparam logic [RSP_W_DEF-1:0] MISR_TAPS = 11'h005;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // One Galois-style MISR step over the low w bits (w <= 32).
   // Bits shifted out of the top feed back into the tap positions.
   function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                             input logic [31:0] rsp,
                                             input int          w);
      logic [31:0] mask_s;
      logic [31:0] fb_s;
      mask_s = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      fb_s   = (((sig >> (w - 1)) & 32'h1) != 32'h0) ? 32'(MISR_TAPS) : 32'h0;
      misr_step = ((sig << 1) ^ fb_s ^ rsp) & mask_s;
   endfunction

endpackage

// File: rtl/test_bist_misr.sv
// Multiple-input signature register compacting the circuit-under-test response.
module test_bist_misr
   import test_bist_pkg::*;
#(
   parameter int RSP_W = RSP_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [RSP_W-1:0] d,
   output logic [RSP_W-1:0] q
);

   logic [RSP_W-1:0] sig_r;

   // Signature register; clear takes priority over compaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_r <= {RSP_W{1'b0}};
      end else if (clr) begin
         sig_r <= {RSP_W{1'b0}};
      end else if (en) begin
         sig_r <= RSP_W'(misr_step(32'(sig_r), 32'(d), RSP_W));
      end else begin
         sig_r <= sig_r;
      end
   end

   assign q = sig_r;

endmodule

// File: rtl/test_bist_ctrl.sv
// BIST controller: walks every PAT_W-bit pattern once, compacts the responses
// in the MISR and reports pass when the final signature matches GOLDEN_SIG.
module test_bist_ctrl
   import test_bist_pkg::*;
#(
   parameter int               PAT_W      = PAT_W_DEF,
   parameter int               RSP_W      = RSP_W_DEF,
   parameter logic [RSP_W-1:0] GOLDEN_SIG = 11'h000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             pause,
   output logic [PAT_W-1:0] pat_out,
   input  logic [RSP_W-1:0] rsp_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [RSP_W-1:0] signature
);

   state_t           state_r, state_n;
   logic [PAT_W-1:0] pat_r, pat_n;
   logic             busy_r, done_r, pass_r, pass_n;
   logic             misr_clr_s, misr_en_s, last_s;
   logic [RSP_W-1:0] sig_s, sig_next_s;

   test_bist_misr #(.RSP_W(RSP_W)) u_misr (
      .clk (clk),
      .rst (rst),
      .clr (misr_clr_s),
      .en  (misr_en_s),
      .d   (rsp_in),
      .q   (sig_s)
   );

   assign last_s     = (pat_r == {PAT_W{1'b1}});
   assign sig_next_s = RSP_W'(misr_step(32'(sig_s), 32'(rsp_in), RSP_W));

   // Next-state, pattern counter and MISR control decode.
   always_comb begin
      state_n    = state_r;
      pat_n      = pat_r;
      pass_n     = pass_r;
      misr_clr_s = 1'b0;
      misr_en_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_n    = RUN;
               pat_n      = {PAT_W{1'b0}};
               pass_n     = 1'b0;
               misr_clr_s = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_n    = IDLE;
               pat_n      = {PAT_W{1'b0}};
               pass_n     = 1'b0;
               misr_clr_s = 1'b1;
            end else if (pause) begin
               state_n = RUN;
            end else begin
               misr_en_s = 1'b1;
               pat_n     = pat_r + PAT_W'(1'b1);
               if (last_s) begin
                  state_n = DONE;
                  pass_n  = (sig_next_s == GOLDEN_SIG);
               end else begin
                  state_n = RUN;
               end
            end
         end
         DONE: begin
            // Abort wins over a simultaneous restart request.
            if (abort) begin
               state_n    = IDLE;
               pat_n      = {PAT_W{1'b0}};
               pass_n     = 1'b0;
               misr_clr_s = 1'b1;
            end else if (start) begin
               state_n    = RUN;
               pat_n      = {PAT_W{1'b0}};
               pass_n     = 1'b0;
               misr_clr_s = 1'b1;
            end else begin
               state_n = DONE;
            end
         end
         default: begin
            state_n    = IDLE;
            pat_n      = {PAT_W{1'b0}};
            pass_n     = 1'b0;
            misr_clr_s = 1'b1;
         end
      endcase
   end

   // State, pattern and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         pat_r   <= {PAT_W{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         pat_r   <= pat_n;
         busy_r  <= (state_n == RUN);
         done_r  <= (state_n == DONE);
         pass_r  <= pass_n;
      end
   end

   assign pat_out   = pat_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign signature = sig_s;

endmodule
